// File: rtl/mor1kx_spr_sysgrp_pkg.sv
// Shared constants for the SPR group-0 responder: address split, register indices,
// FSM encoding and the EVBAR writable-bit mask.
package mor1kx_spr_sysgrp_pkg;

    localparam int SPR_ADDR_W  = 16;
    localparam int SPR_DAT_W   = 32;
    localparam int SPR_GRP_W   = 5;
    localparam int SPR_GRP_MSB = 15;
    localparam int SPR_GRP_LSB = 11;
    localparam int SPR_IDX_W   = 11;
    localparam int WAIT_W      = 4;

    localparam logic [SPR_GRP_W-1:0] SPR_GRP_SYS = '0;

    localparam logic [SPR_IDX_W-1:0]
        IDX_VR       = 11'd0,
        IDX_UPR      = 11'd1,
        IDX_CPUCFGR  = 11'd2,
        IDX_DMMUCFGR = 11'd3,
        IDX_IMMUCFGR = 11'd4,
        IDX_DCCFGR   = 11'd5,
        IDX_ICCFGR   = 11'd6,
        IDX_DCFGR    = 11'd7,
        IDX_PCCFGR   = 11'd8,
        IDX_VR2      = 11'd9,
        IDX_AVR      = 11'd10,
        IDX_EVBAR    = 11'd11,
        IDX_AECR     = 11'd12,
        IDX_AESR     = 11'd13;

    localparam logic [SPR_DAT_W-1:0] EVBAR_MASK = 32'hFFFF_E000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2,
        ST_GAP  = 2'd3
    } state_t;

    function automatic logic idx_is_ro(input logic [SPR_IDX_W-1:0] idx);
        return idx <= IDX_AVR;
    endfunction

    function automatic logic idx_is_rw(input logic [SPR_IDX_W-1:0] idx);
        return (idx >= IDX_EVBAR) && (idx <= IDX_AESR);
    endfunction

endpackage

// File: rtl/mor1kx_spr_sysgrp_resp_if.sv
// SPR bus between the CPU control unit (master) and a group responder (slave).
// spr_bus_err_o exists only when MOR1KX_SPR_SYSGRP_ACCESS_ERR_EN is defined.
interface mor1kx_spr_sysgrp_resp_if;
    import mor1kx_spr_sysgrp_pkg::*;

    logic [SPR_ADDR_W-1:0] spr_bus_addr_i;
    logic                  spr_bus_stb_i;
    logic                  spr_bus_we_i;
    logic [SPR_DAT_W-1:0]  spr_bus_dat_i;
    logic [SPR_DAT_W-1:0]  spr_bus_dat_o;
    logic                  spr_bus_ack_o;
`ifdef MOR1KX_SPR_SYSGRP_ACCESS_ERR_EN
    logic                  spr_bus_err_o;

    modport master (output spr_bus_addr_i, spr_bus_stb_i, spr_bus_we_i, spr_bus_dat_i,
                    input  spr_bus_dat_o, spr_bus_ack_o, spr_bus_err_o);
    modport slave  (input  spr_bus_addr_i, spr_bus_stb_i, spr_bus_we_i, spr_bus_dat_i,
                    output spr_bus_dat_o, spr_bus_ack_o, spr_bus_err_o);
`else
    modport master (output spr_bus_addr_i, spr_bus_stb_i, spr_bus_we_i, spr_bus_dat_i,
                    input  spr_bus_dat_o, spr_bus_ack_o);
    modport slave  (input  spr_bus_addr_i, spr_bus_stb_i, spr_bus_we_i, spr_bus_dat_i,
                    output spr_bus_dat_o, spr_bus_ack_o);
`endif
endinterface

// File: rtl/mor1kx_spr_sysgrp_regs.sv
// Writable group-0 registers EVBAR/AECR/AESR; writes land on the edge where i_we is high.
// AESR is sticky: set bits OR in every cycle and win over a simultaneous software write.
module mor1kx_spr_sysgrp_regs
    import mor1kx_spr_sysgrp_pkg::*;
#(
    parameter bit EVBAR_EN = 1'b0,
    parameter bit AECSR_EN = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_we,
    input  logic [SPR_IDX_W-1:0] i_idx,
    input  logic [SPR_DAT_W-1:0] i_wdat,
    input  logic [SPR_DAT_W-1:0] i_aesr_set,
    output logic [SPR_DAT_W-1:0] o_evbar,
    output logic [SPR_DAT_W-1:0] o_aecr,
    output logic [SPR_DAT_W-1:0] o_aesr
);

    logic [SPR_DAT_W-1:0] r_evbar;
    logic [SPR_DAT_W-1:0] r_aecr;
    logic [SPR_DAT_W-1:0] r_aesr;

    logic w_we_evbar;
    logic w_we_aecr;
    logic w_we_aesr;

    // Disabled features never load, so their registers hold the reset value of 0.
    assign w_we_evbar = EVBAR_EN && i_we && (i_idx == IDX_EVBAR);
    assign w_we_aecr  = AECSR_EN && i_we && (i_idx == IDX_AECR);
    assign w_we_aesr  = AECSR_EN && i_we && (i_idx == IDX_AESR);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_evbar <= '0;
            r_aecr  <= '0;
            r_aesr  <= '0;
        end else begin
            if (w_we_evbar) r_evbar <= i_wdat & EVBAR_MASK;
            if (w_we_aecr)  r_aecr  <= i_wdat;
            if (AECSR_EN)   r_aesr  <= (w_we_aesr ? i_wdat : r_aesr) | i_aesr_set;
        end
    end

    assign o_evbar = r_evbar;
    assign o_aecr  = r_aecr;
    assign o_aesr  = r_aesr;

endmodule

// File: rtl/mor1kx_spr_sysgrp_resp.sv
// SPR group-0 responder: config-word reads plus EVBAR/AECR/AESR; ack 2+OPTION_WAIT_STATES cycles
// after stb, one idle cycle after each ack, stb drop before ack aborts. MOR1KX_SPR_SYSGRP_ACCESS_ERR_EN adds err.
module mor1kx_spr_sysgrp_resp
    import mor1kx_spr_sysgrp_pkg::*;
#(
    parameter string FEATURE_EVBAR      = "NONE",
    parameter string FEATURE_AECSR      = "NONE",
    parameter int    OPTION_WAIT_STATES = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mor1kx_spr_sysgrp_resp_if.slave spr_bus,
    input  logic [SPR_DAT_W-1:0] cfg_vr_i,
    input  logic [SPR_DAT_W-1:0] cfg_vr2_i,
    input  logic [SPR_DAT_W-1:0] cfg_upr_i,
    input  logic [SPR_DAT_W-1:0] cfg_cpucfgr_i,
    input  logic [SPR_DAT_W-1:0] cfg_dmmucfgr_i,
    input  logic [SPR_DAT_W-1:0] cfg_immucfgr_i,
    input  logic [SPR_DAT_W-1:0] cfg_dccfgr_i,
    input  logic [SPR_DAT_W-1:0] cfg_iccfgr_i,
    input  logic [SPR_DAT_W-1:0] cfg_dcfgr_i,
    input  logic [SPR_DAT_W-1:0] cfg_pccfgr_i,
    input  logic [SPR_DAT_W-1:0] cfg_avr_i,
    input  logic [SPR_DAT_W-1:0] aesr_set_i,
    output logic [SPR_DAT_W-1:0] evbar_o,
    output logic [SPR_DAT_W-1:0] aecr_o,
    output logic [SPR_DAT_W-1:0] aesr_o
);

    localparam bit                EVBAR_EN  = (FEATURE_EVBAR == "ENABLED");
    localparam bit                AECSR_EN  = (FEATURE_AECSR == "ENABLED");
    localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(OPTION_WAIT_STATES);

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [WAIT_W-1:0]      r_cnt;
    logic [SPR_IDX_W-1:0]   r_idx;
    logic                   r_we;
    logic [SPR_DAT_W-1:0]   r_wdat;
    logic [SPR_DAT_W-1:0]   r_rdat;
    logic [SPR_DAT_W-1:0]   w_rdat;
    logic                   w_grp_hit;
    logic                   w_capture;
    logic                   w_launch;
    logic                   w_commit;

    assign w_grp_hit = (spr_bus.spr_bus_addr_i[SPR_GRP_MSB:SPR_GRP_LSB] == SPR_GRP_SYS);

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        w_launch    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (spr_bus.spr_bus_stb_i && w_grp_hit) begin
                    w_state_nxt = ST_WAIT;
                    w_capture   = 1'b1;
                end
            end
            ST_WAIT: begin
                if (!spr_bus.spr_bus_stb_i) begin
                    w_state_nxt = ST_IDLE;
                end else if (r_cnt == '0) begin
                    w_state_nxt = ST_ACK;
                    w_launch    = 1'b1;
                end
            end
            ST_ACK:  w_state_nxt = ST_GAP;
            ST_GAP:  w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_rdat = '0;
        case (r_idx)
            IDX_VR:       w_rdat = cfg_vr_i;
            IDX_UPR:      w_rdat = cfg_upr_i;
            IDX_CPUCFGR:  w_rdat = cfg_cpucfgr_i;
            IDX_DMMUCFGR: w_rdat = cfg_dmmucfgr_i;
            IDX_IMMUCFGR: w_rdat = cfg_immucfgr_i;
            IDX_DCCFGR:   w_rdat = cfg_dccfgr_i;
            IDX_ICCFGR:   w_rdat = cfg_iccfgr_i;
            IDX_DCFGR:    w_rdat = cfg_dcfgr_i;
            IDX_PCCFGR:   w_rdat = cfg_pccfgr_i;
            IDX_VR2:      w_rdat = cfg_vr2_i;
            IDX_AVR:      w_rdat = cfg_avr_i;
            IDX_EVBAR:    w_rdat = evbar_o;
            IDX_AECR:     w_rdat = aecr_o;
            IDX_AESR:     w_rdat = aesr_o;
            default:      w_rdat = '0;
        endcase
    end

    // Read data is sampled on the WAIT->ACK edge and cleared one cycle later,
    // so dat_o is nonzero only during the ACK cycle of a read.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_idx  <= '0;
            r_we   <= 1'b0;
            r_wdat <= '0;
            r_rdat <= '0;
        end else begin
            if (w_capture) begin
                r_cnt  <= WAIT_INIT;
                r_idx  <= spr_bus.spr_bus_addr_i[SPR_IDX_W-1:0];
                r_we   <= spr_bus.spr_bus_we_i;
                r_wdat <= spr_bus.spr_bus_dat_i;
            end else if ((r_state == ST_WAIT) && (r_cnt != '0)) begin
                r_cnt <= r_cnt - 1'b1;
            end
            r_rdat <= (w_launch && !r_we) ? w_rdat : '0;
        end
    end

`ifdef MOR1KX_SPR_SYSGRP_ACCESS_ERR_EN
    logic r_err;
    logic w_access_err;

    assign w_access_err = !idx_is_rw(r_idx) && (r_we || !idx_is_ro(r_idx));

    always_ff @(posedge clk) begin
        if (!rst_n) r_err <= 1'b0;
        else        r_err <= w_launch && w_access_err;
    end

    assign spr_bus.spr_bus_err_o = r_err;
    assign w_commit = (r_state == ST_ACK) && r_we && !r_err;
`else
    assign w_commit = (r_state == ST_ACK) && r_we;
`endif

    assign spr_bus.spr_bus_ack_o = (r_state == ST_ACK);
    assign spr_bus.spr_bus_dat_o = r_rdat;

    mor1kx_spr_sysgrp_regs #(
        .EVBAR_EN (EVBAR_EN),
        .AECSR_EN (AECSR_EN)
    ) u_regs (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_we       (w_commit),
        .i_idx      (r_idx),
        .i_wdat     (r_wdat),
        .i_aesr_set (aesr_set_i),
        .o_evbar    (evbar_o),
        .o_aecr     (aecr_o),
        .o_aesr     (aesr_o)
    );

endmodule

// File: tb/tb_mor1kx_spr_sysgrp_resp.sv
// Directed bench for the SPR group-0 responder: one instance with no wait states, one with three.
module tb_mor1kx_spr_sysgrp_resp;
    import mor1kx_spr_sysgrp_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [31:0] cfg [0:10];
    logic [31:0] aesr_set;
    logic [31:0] evbar0, aecr0, aesr0, evbar3, aecr3, aesr3;

    int n_vec = 0;
    int n_bad = 0;

    logic [31:0] q_dat [$];
    logic        q_err [$];
    int          q_lat [$];

    mor1kx_spr_sysgrp_resp_if bus0 ();
    mor1kx_spr_sysgrp_resp_if bus3 ();

    mor1kx_spr_sysgrp_resp #(
        .FEATURE_EVBAR ("ENABLED"), .FEATURE_AECSR ("ENABLED"), .OPTION_WAIT_STATES (0)
    ) dut0 (
        .clk (clk), .rst_n (rst_n), .spr_bus (bus0.slave),
        .cfg_vr_i (cfg[0]), .cfg_upr_i (cfg[1]), .cfg_cpucfgr_i (cfg[2]),
        .cfg_dmmucfgr_i (cfg[3]), .cfg_immucfgr_i (cfg[4]), .cfg_dccfgr_i (cfg[5]),
        .cfg_iccfgr_i (cfg[6]), .cfg_dcfgr_i (cfg[7]), .cfg_pccfgr_i (cfg[8]),
        .cfg_vr2_i (cfg[9]), .cfg_avr_i (cfg[10]), .aesr_set_i (aesr_set),
        .evbar_o (evbar0), .aecr_o (aecr0), .aesr_o (aesr0)
    );

    mor1kx_spr_sysgrp_resp #(
        .FEATURE_EVBAR ("ENABLED"), .FEATURE_AECSR ("ENABLED"), .OPTION_WAIT_STATES (3)
    ) dut3 (
        .clk (clk), .rst_n (rst_n), .spr_bus (bus3.slave),
        .cfg_vr_i (cfg[0]), .cfg_upr_i (cfg[1]), .cfg_cpucfgr_i (cfg[2]),
        .cfg_dmmucfgr_i (cfg[3]), .cfg_immucfgr_i (cfg[4]), .cfg_dccfgr_i (cfg[5]),
        .cfg_iccfgr_i (cfg[6]), .cfg_dcfgr_i (cfg[7]), .cfg_pccfgr_i (cfg[8]),
        .cfg_vr2_i (cfg[9]), .cfg_avr_i (cfg[10]), .aesr_set_i (aesr_set),
        .evbar_o (evbar3), .aecr_o (aecr3), .aesr_o (aesr3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int w, input logic stb, input logic [15:0] a,
                         input logic we, input logic [31:0] d);
        if (w == 0) begin
            bus0.spr_bus_stb_i = stb; bus0.spr_bus_addr_i = a;
            bus0.spr_bus_we_i  = we;  bus0.spr_bus_dat_i  = d;
        end else begin
            bus3.spr_bus_stb_i = stb; bus3.spr_bus_addr_i = a;
            bus3.spr_bus_we_i  = we;  bus3.spr_bus_dat_i  = d;
        end
    endtask

    function automatic logic get_ack(input int w);
        return (w == 0) ? bus0.spr_bus_ack_o : bus3.spr_bus_ack_o;
    endfunction

    function automatic logic [31:0] get_dat(input int w);
        return (w == 0) ? bus0.spr_bus_dat_o : bus3.spr_bus_dat_o;
    endfunction

`ifdef MOR1KX_SPR_SYSGRP_ACCESS_ERR_EN
    function automatic logic get_err(input int w);
        return (w == 0) ? bus0.spr_bus_err_o : bus3.spr_bus_err_o;
    endfunction
`endif

    // Pops and checks one scoreboard entry when ack shows up; the bus is
    // scrambled in cycle 1 to show that the request was captured.
    task automatic access(input int w, input logic [15:0] a, input logic we, input logic [31:0] d,
                          input logic [31:0] exp_dat, input logic exp_err, input int exp_lat,
                          input logic [15:0] a_late, input logic [31:0] aset_ack);
        bit          got;
        logic [31:0] dirty;
        got   = 1'b0;
        dirty = '0;
        q_dat.push_back(exp_dat);
        q_err.push_back(exp_err);
        q_lat.push_back(exp_lat);
        drive(w, 1'b1, a, we, d);
        for (int c = 0; c < 40 && !got; c++) begin
            if (get_ack(w)) begin
                got = 1'b1;
                chk("latency", 32'(c), 32'(q_lat.pop_front()));
                chk("rdata", get_dat(w), q_dat.pop_front());
`ifdef MOR1KX_SPR_SYSGRP_ACCESS_ERR_EN
                chk("err", {31'b0, get_err(w)}, {31'b0, q_err.pop_front()});
`else
                void'(q_err.pop_front());
`endif
                drive(w, 1'b0, 16'h0, 1'b0, 32'h0);
                aesr_set = aset_ack;
                step();
                aesr_set = '0;
                chk("ack_gap", {31'b0, get_ack(w)}, 32'h0);
                chk("dat_gap", get_dat(w), 32'h0);
                step();
            end else begin
                dirty |= get_dat(w);
                if (c == 1) drive(w, 1'b1, a_late, !we, ~d);
                step();
            end
        end
        chk("ack_seen", {31'b0, got}, 32'h1);
        chk("dat_before_ack", dirty, 32'h0);
        if (!got) begin
            drive(w, 1'b0, 16'h0, 1'b0, 32'h0);
            void'(q_dat.pop_front()); void'(q_err.pop_front()); void'(q_lat.pop_front());
        end
    endtask

    task automatic count_acks(input int w, input int n, output int acks);
        acks = 0;
        for (int i = 0; i < n; i++) begin
            if (get_ack(w)) acks++;
            step();
        end
    endtask

    initial begin
        int          acks;
        int          a1, a2;
        logic [31:0] b2b_dat;

        rst_n    = 1'b0;
        aesr_set = '0;
        for (int i = 0; i <= 10; i++) cfg[i] = 32'hC0DE_0000 | 32'(i * 32'h111);
        cfg[2] = 32'h0000_0620;
        drive(0, 1'b0, 16'h0, 1'b0, 32'h0);
        drive(3, 1'b0, 16'h0, 1'b0, 32'h0);
        step(); step();
        chk("rst_ack", {31'b0, bus0.spr_bus_ack_o}, 32'h0);
        chk("rst_dat", bus0.spr_bus_dat_o, 32'h0);
        chk("rst_evbar", evbar0, 32'h0);
        chk("rst_aecr", aecr0, 32'h0);
        chk("rst_aesr", aesr0, 32'h0);
`ifdef MOR1KX_SPR_SYSGRP_ACCESS_ERR_EN
        chk("rst_err", {31'b0, bus0.spr_bus_err_o}, 32'h0);
`endif
        rst_n = 1'b1;
        step();

        // Every read-only config word, no wait states.
        for (int i = 0; i <= 10; i++)
            access(0, 16'(i), 1'b0, 32'h0, cfg[i], 1'b0, 2, 16'h0003, 32'h0);

        // Three wait states; bus changes after capture are ignored.
        access(3, 16'h0009, 1'b0, 32'h0, cfg[9], 1'b0, 5, 16'h0002, 32'h0);

        // Abort: stb drops in cycle 2 of a waited access.
        drive(3, 1'b1, 16'h0009, 1'b0, 32'h0);
        step(); step();
        drive(3, 1'b0, 16'h0009, 1'b0, 32'h0);
        count_acks(3, 12, acks);
        chk("abort_no_ack", 32'(acks), 32'h0);
        access(3, 16'h0001, 1'b0, 32'h0, cfg[1], 1'b0, 5, 16'h0001, 32'h0);

        // EVBAR low bits are hardwired to zero.
        access(0, 16'h000B, 1'b1, 32'hFFFF_FFFF, 32'h0, 1'b0, 2, 16'h000B, 32'h0);
        chk("evbar_o", evbar0, 32'hFFFF_E000);
        access(0, 16'h000B, 1'b0, 32'h0, 32'hFFFF_E000, 1'b0, 2, 16'h000B, 32'h0);

        access(0, 16'h000C, 1'b1, 32'hDEAD_BEEF, 32'h0, 1'b0, 2, 16'h000C, 32'h0);
        chk("aecr_o", aecr0, 32'hDEAD_BEEF);
        access(0, 16'h000C, 1'b0, 32'h0, 32'hDEAD_BEEF, 1'b0, 2, 16'h000C, 32'h0);

        // AESR sticky set, then a clearing write racing a new set bit.
        aesr_set = 32'h1;
        step();
        aesr_set = '0;
        chk("aesr_set", aesr0, 32'h1);
        step();
        chk("aesr_sticky", aesr0, 32'h1);
        access(0, 16'h000D, 1'b1, 32'h0, 32'h0, 1'b0, 2, 16'h000D, 32'h4);
        chk("aesr_set_wins", aesr0, 32'h4);
        chk("aesr_other_inst", aesr3, 32'h5);
        access(0, 16'h000D, 1'b0, 32'h0, 32'h4, 1'b0, 2, 16'h000D, 32'h0);

        // Read-only and unmapped targets: acked, no state change.
        access(0, 16'h0000, 1'b1, 32'h1234_5678, 32'h0, 1'b1, 2, 16'h0000, 32'h0);
        access(0, 16'h0000, 1'b0, 32'h0, cfg[0], 1'b0, 2, 16'h0000, 32'h0);
        access(0, 16'h0020, 1'b0, 32'h0, 32'h0, 1'b1, 2, 16'h0020, 32'h0);
        access(0, 16'h000E, 1'b1, 32'hFFFF_FFFF, 32'h0, 1'b1, 2, 16'h000E, 32'h0);
        chk("unmapped_evbar", evbar0, 32'hFFFF_E000);
        chk("unmapped_aecr", aecr0, 32'hDEAD_BEEF);
        chk("unmapped_aesr", aesr0, 32'h4);

        // Foreign group, index aliasing EVBAR.
        drive(0, 1'b1, 16'h080B, 1'b1, 32'h0);
        count_acks(0, 10, acks);
        drive(0, 1'b0, 16'h0, 1'b0, 32'h0);
        chk("foreign_no_ack", 32'(acks), 32'h0);
        chk("foreign_evbar", evbar0, 32'hFFFF_E000);
        step();

        // Back-to-back: stb held through GAP, second ack four cycles after the first.
        q_dat.push_back(cfg[1]);
        q_dat.push_back(cfg[1]);
        a1 = -1;
        a2 = -1;
        drive(0, 1'b1, 16'h0001, 1'b0, 32'h0);
        for (int c = 0; c < 20 && a2 < 0; c++) begin
            if (bus0.spr_bus_ack_o) begin
                b2b_dat = q_dat.pop_front();
                chk("b2b_dat", bus0.spr_bus_dat_o, b2b_dat);
                if (a1 < 0) a1 = c;
                else        a2 = c;
            end
            if (a2 < 0) step();
        end
        drive(0, 1'b0, 16'h0, 1'b0, 32'h0);
        chk("b2b_first", 32'(a1), 32'h2);
        chk("b2b_second", 32'(a2), 32'h6);
        while (q_dat.size() > 0) void'(q_dat.pop_front());
        step(); step();

        // Reset in the middle of a write.
        drive(0, 1'b1, 16'h000C, 1'b1, 32'h5555_5555);
        step();
        rst_n = 1'b0;
        drive(0, 1'b0, 16'h0, 1'b0, 32'h0);
        step();
        rst_n = 1'b1;
        count_acks(0, 6, acks);
        chk("rst_mid_no_ack", 32'(acks), 32'h0);
        chk("rst_mid_aecr", aecr0, 32'h0);
        access(0, 16'h0002, 1'b0, 32'h0, 32'h0000_0620, 1'b0, 2, 16'h0002, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
